vx_axi_wdata_sequencer: RTL and testbench

- Sits directly downstream of the AXI write-address arbiter.
- Records the order in which AW grants were issued (source index plus burst length) in an order queue. Steers W beats from the matching source port to the single AXI master W channel until that burst's last beat, then advances to the next grant.
- Keeps W bursts in AW grant order as AXI requires. Flags wlast/length mismatches.

---
 rtl/vx_axi_pkg.sv | 21 ++
 rtl/vx_axi_wdata_sequencer_fifo.sv | 56 +++++
 rtl/vx_axi_wdata_sequencer.sv | 113 +++++++++++
 tb/tb_vx_axi_wdata_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_axi_pkg.sv
// Shared AXI write-channel types for the vx_axi blocks.
// Beat and order-entry layouts plus common widths.
package vx_axi_pkg;

  localparam int AXI_LEN_W  = 8;
  localparam int AXI_DATA_W = 512;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_SEL_W  = 8;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } axi_w_beat_t;

  typedef struct packed {
    logic [AXI_SEL_W-1:0] sel;
    logic [AXI_LEN_W-1:0] len;
  } order_entry_t;

endpackage

// File: rtl/vx_axi_wdata_sequencer_fifo.sv
// Synchronous FIFO queue with registered full/empty and occupancy.
// DEPTH must be a power of two so the pointers wrap for free.
module VX_fifo_queue #(
  parameter int DATAW = 8,
  parameter int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int SIZEW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [SIZEW-1:0] size
);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (size == '0);
  assign full    = (size == SIZEW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      size   <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   size <= size + SIZEW'(1);
        2'b01:   size <= size - SIZEW'(1);
        default: size <= size;
      endcase
    end
  end

endmodule

// File: rtl/vx_axi_wdata_sequencer.sv
// Steers slave W bursts to the master W port in AW grant order.
// Burst length comes from the recorded awlen, not from wlast.
module vx_axi_wdata_sequencer
  import vx_axi_pkg::*;
#(
  parameter int NUM_INPUTS     = 2,
  parameter int AXI_DATA_WIDTH = 512,
  parameter int ORDER_DEPTH    = 8,
  parameter int SEL_BITS       = $clog2(NUM_INPUTS),
  localparam int SW  = AXI_DATA_WIDTH / 8,
  localparam int CW  = $clog2(ORDER_DEPTH + 1),
  localparam int QDW = SEL_BITS + AXI_LEN_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         grant_valid,
  output logic                         grant_ready,
  input  logic [SEL_BITS-1:0]          grant_sel,
  input  logic [AXI_LEN_W-1:0]         grant_len,
  input  logic [NUM_INPUTS-1:0]        s_axi_wvalid,
  output logic [NUM_INPUTS-1:0]        s_axi_wready,
  input  logic [NUM_INPUTS*AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [NUM_INPUTS*SW-1:0]     s_axi_wstrb,
  input  logic [NUM_INPUTS-1:0]        s_axi_wlast,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]    m_axi_wdata,
  output logic [SW-1:0]                m_axi_wstrb,
  output logic                         m_axi_wlast,
  output logic [CW-1:0]                pending_count,
  output logic                         wlast_err
);

  logic                 q_reset;
  logic                 q_push;
  logic                 q_pop;
  logic [QDW-1:0]       q_din;
  logic [QDW-1:0]       q_dout;
  logic                 q_empty;
  logic                 q_full;
  logic [CW-1:0]        q_size;

  order_entry_t         head;
  logic                 head_valid;
  logic [AXI_LEN_W-1:0] beat_cnt;
  logic                 is_last;
  logic                 src_last;
  logic                 fire;

  assign q_reset = ~reset_n;
  assign q_din   = {grant_sel, grant_len};
  assign q_push  = grant_valid & grant_ready;
  assign q_pop   = fire & is_last;

  VX_fifo_queue #(
    .DATAW (QDW),
    .DEPTH (ORDER_DEPTH)
  ) order_q (
    .clk      (clk),
    .reset    (q_reset),
    .push     (q_push),
    .pop      (q_pop),
    .data_in  (q_din),
    .data_out (q_dout),
    .empty    (q_empty),
    .full     (q_full),
    .size     (q_size)
  );

  assign grant_ready   = ~q_full;
  assign pending_count = q_size;
  assign head_valid    = ~q_empty;

  assign head.sel = AXI_SEL_W'(q_dout[AXI_LEN_W +: SEL_BITS]);
  assign head.len = q_dout[AXI_LEN_W-1:0];

  assign is_last = (beat_cnt == head.len);

  always_comb begin
    m_axi_wvalid = 1'b0;
    m_axi_wdata  = '0;
    m_axi_wstrb  = '0;
    src_last     = 1'b0;
    s_axi_wready = '0;
    if (head_valid) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (head.sel == AXI_SEL_W'(i)) begin
          m_axi_wvalid    = s_axi_wvalid[i];
          m_axi_wdata     = s_axi_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
          m_axi_wstrb     = s_axi_wstrb[i*SW +: SW];
          src_last        = s_axi_wlast[i];
          s_axi_wready[i] = m_axi_wready;
        end
      end
    end
  end

  // wlast is regenerated from the counter so a bad source cannot cut a burst
  assign m_axi_wlast = head_valid & is_last;
  assign fire        = m_axi_wvalid & m_axi_wready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt  <= '0;
      wlast_err <= 1'b0;
    end else if (fire) begin
      beat_cnt <= is_last ? '0 : beat_cnt + AXI_LEN_W'(1);
      if (src_last != is_last)
        wlast_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_axi_wdata_sequencer.sv
// Randomized bench for vx_axi_wdata_sequencer.
// Model: grant-order queue of bursts, per-source beat queues.
module tb_vx_axi_wdata_sequencer;

  localparam int NI    = 2;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             grant_valid;
  logic             grant_ready;
  logic [0:0]       grant_sel;
  logic [7:0]       grant_len;
  logic [NI-1:0]    s_axi_wvalid;
  logic [NI-1:0]    s_axi_wready;
  logic [NI*DW-1:0] s_axi_wdata;
  logic [NI*SW-1:0] s_axi_wstrb;
  logic [NI-1:0]    s_axi_wlast;
  logic             m_axi_wvalid;
  logic             m_axi_wready;
  logic [DW-1:0]    m_axi_wdata;
  logic [SW-1:0]    m_axi_wstrb;
  logic             m_axi_wlast;
  logic [CW-1:0]    pending_count;
  logic             wlast_err;

  always #5 clk = ~clk;

  vx_axi_wdata_sequencer #(
    .NUM_INPUTS     (NI),
    .AXI_DATA_WIDTH (DW),
    .ORDER_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .grant_valid   (grant_valid),
    .grant_ready   (grant_ready),
    .grant_sel     (grant_sel),
    .grant_len     (grant_len),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .pending_count (pending_count),
    .wlast_err     (wlast_err)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  typedef struct {
    int sel;
    int len;
  } grant_t;

  beat_t  sq[NI][$];
  grant_t gq[$];
  grant_t plan[$];
  int     done;
  bit     err;
  bit     src_v[NI];
  bit     gnt_v;
  bit     mrdy;
  int     n_cmp;
  int     n_bad;
  int     rdy_pct;
  int     gnt_pct;
  bit     inj;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_plan();
    grant_t g;
    int     bad;
    beat_t  b;
    g.sel = $urandom_range(0, NI - 1);
    g.len = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6)
                                        : $urandom_range(0, 1);
    bad = (inj && $urandom_range(0, 4) == 0) ? $urandom_range(0, g.len) : -1;
    for (int j = 0; j <= g.len; j++) begin
      b.d = $urandom;
      b.s = SW'($urandom);
      b.l = (j == g.len) ^ (j == bad);
      sq[g.sel].push_back(b);
    end
    plan.push_back(g);
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      s_axi_wvalid[i] = src_v[i];
      if (sq[i].size() > 0) begin
        s_axi_wdata[i*DW +: DW] = sq[i][0].d;
        s_axi_wstrb[i*SW +: SW] = sq[i][0].s;
        s_axi_wlast[i]          = sq[i][0].l;
      end else begin
        s_axi_wdata[i*DW +: DW] = '0;
        s_axi_wstrb[i*SW +: SW] = '0;
        s_axi_wlast[i]          = 1'b0;
      end
    end
    m_axi_wready = mrdy;
    grant_valid  = gnt_v;
    grant_sel    = (plan.size() > 0) ? 1'(plan[0].sel) : 1'b0;
    grant_len    = (plan.size() > 0) ? 8'(plan[0].len) : 8'd0;
  endtask

  task automatic clear_model();
    gq.delete();
    plan.delete();
    for (int i = 0; i < NI; i++) begin
      sq[i].delete();
      src_v[i] = 1'b0;
    end
    done  = 0;
    err   = 1'b0;
    gnt_v = 1'b0;
    mrdy  = 1'b0;
  endtask

  task automatic step();
    bit            push;
    bit            fire;
    bit            last;
    int            k;
    bit            ev;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic [NI-1:0] er;
    beat_t         b;
    @(negedge clk);
    push = gnt_v && (gq.size() < DEPTH);
    fire = 1'b0;
    last = 1'b0;
    k    = 0;
    ev   = 1'b0;
    ed   = '0;
    es   = '0;
    er   = '0;
    if (gq.size() > 0) begin
      k     = gq[0].sel;
      last  = (done == gq[0].len);
      ev    = src_v[k];
      ed    = sq[k][0].d;
      es    = sq[k][0].s;
      er[k] = mrdy;
      fire  = ev & mrdy;
    end
    check("wvalid", 64'(m_axi_wvalid), 64'(ev));
    check("wdata", 64'(m_axi_wdata), 64'(ed));
    check("wstrb", 64'(m_axi_wstrb), 64'(es));
    check("wlast", 64'(m_axi_wlast), 64'(last));
    check("s_wready", 64'(s_axi_wready), 64'(er));
    check("pending", 64'(pending_count), 64'(gq.size()));
    check("grant_ready", 64'(grant_ready), 64'(gq.size() < DEPTH));
    check("wlast_err", 64'(wlast_err), 64'(err));
    @(posedge clk);
    #1;
    if (fire) begin
      b = sq[k].pop_front();
      if (b.l != last)
        err = 1'b1;
      src_v[k] = 1'b0;
      if (last) begin
        void'(gq.pop_front());
        done = 0;
      end else begin
        done++;
      end
    end
    if (push)
      gq.push_back(plan.pop_front());
    while (plan.size() < 4)
      new_plan();
    for (int i = 0; i < NI; i++)
      if (!src_v[i])
        src_v[i] = (sq[i].size() > 0) && ($urandom_range(0, 99) < 70);
    mrdy  = ($urandom_range(0, 99) < rdy_pct);
    gnt_v = ($urandom_range(0, 99) < gnt_pct);
    drive();
  endtask

  task automatic run(int n, int rp, int gp, bit ij);
    rdy_pct = rp;
    gnt_pct = gp;
    inj     = ij;
    for (int c = 0; c < n; c++)
      step();
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    clear_model();
    drive();
    #12;
    check("rst_pending", 64'(pending_count), 64'd0);
    check("rst_grant_ready", 64'(grant_ready), 64'd1);
    check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    check("rst_s_wready", 64'(s_axi_wready), 64'd0);
    check("rst_wlast_err", 64'(wlast_err), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    run(1500, 80, 50, 1'b0);
    run(400, 10, 90, 1'b0);
    run(400, 100, 100, 1'b0);
    run(400, 70, 60, 1'b1);

    // catch a burst partway through, then reset between edges
    for (int c = 0; c < 500 && done == 0; c++)
      step();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_wvalid", 64'(m_axi_wvalid), 64'd0);
    check("arst_s_wready", 64'(s_axi_wready), 64'd0);
    check("arst_pending", 64'(pending_count), 64'd0);
    check("arst_grant_ready", 64'(grant_ready), 64'd1);
    check("arst_wlast_err", 64'(wlast_err), 64'd0);
    clear_model();
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    run(400, 75, 50, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
